// File: rtl/parallel_to_serial_stream.sv
// Ready/valid parallel-to-serial converter: splits each WIDTH-bit word into LANE-bit beats.
// A one-word holding buffer lets consecutive words stream without a gap; an idle word bypasses straight to the output.
module parallel_to_serial_stream #(
    parameter int WIDTH     = 8,
    parameter int LANE      = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_parallel_valid,
    output logic             o_parallel_ready,
    input  logic [WIDTH-1:0] i_parallel_data,
    output logic             o_serial_valid,
    input  logic             i_serial_ready,
    output logic [LANE-1:0]  o_serial_data,
    output logic             o_serial_last,
    output logic             o_busy
);
    // state    | meaning
    // S_IDLE   | nothing in flight; the offered word is bypassed to the serial side
    // S_ACTIVE | shift register holds a word; r_cnt selects the beat on the output

    localparam int BEATS = WIDTH / LANE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);

    generate
        if (LANE < 1 || LANE > WIDTH || (WIDTH % LANE) != 0) begin : g_bad_params
            $error("parallel_to_serial_stream: LANE must divide WIDTH and be <= WIDTH");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_sh, w_sh_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_hold, w_hold_nxt;
    logic              r_hold_valid, w_hold_valid_nxt;

    logic              w_ready, w_valid, w_last;
    logic [LANE-1:0]   w_data;

    function automatic logic [LANE-1:0] chunk(input logic [WIDTH-1:0] word, input logic [CW-1:0] idx);
        int               pos;
        logic [WIDTH-1:0] shifted;
        pos     = (MSB_FIRST != 0) ? (BEATS - 1 - int'(idx)) : int'(idx);
        shifted = word >> (pos * LANE);
        return shifted[LANE-1:0];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sh         <= w_sh_nxt;
            r_cnt        <= w_cnt_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_sh_nxt         = r_sh;
        w_cnt_nxt        = r_cnt;
        w_hold_nxt       = r_hold;
        w_hold_valid_nxt = r_hold_valid;
        w_ready          = 1'b0;
        w_valid          = 1'b0;
        w_last           = 1'b0;
        w_data           = '0;

        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                w_valid = i_parallel_valid;
                w_data  = chunk(i_parallel_data, '0);
                w_last  = i_parallel_valid && (BEATS == 1);
                if (i_parallel_valid) begin
                    if (!i_serial_ready) begin
                        // beat 0 was offered but not taken; replay it from the shift register
                        w_sh_nxt    = i_parallel_data;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ACTIVE;
                    end else if (BEATS > 1) begin
                        w_sh_nxt    = i_parallel_data;
                        w_cnt_nxt   = CW'(1);
                        w_state_nxt = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                w_ready = !r_hold_valid;
                w_valid = 1'b1;
                w_data  = chunk(r_sh, r_cnt);
                w_last  = (r_cnt == LAST_IDX);
                if (i_serial_ready) begin
                    if (!w_last) begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end else if (r_hold_valid) begin
                        w_sh_nxt         = r_hold;
                        w_cnt_nxt        = '0;
                        w_hold_valid_nxt = 1'b0;
                    end else if (i_parallel_valid) begin
                        w_sh_nxt  = i_parallel_data;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                // a word arriving on the final handshake goes straight to the shift register instead
                if (!r_hold_valid && i_parallel_valid && !(i_serial_ready && w_last)) begin
                    w_hold_nxt       = i_parallel_data;
                    w_hold_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // outputs are forced quiet while reset is asserted, independent of the clock
    assign o_parallel_ready = i_rst_n & w_ready;
    assign o_serial_valid   = i_rst_n & w_valid;
    assign o_serial_last    = i_rst_n & w_last;
    assign o_serial_data    = w_data & {LANE{i_rst_n}};
    assign o_busy           = i_rst_n & ((r_state == S_ACTIVE) | r_hold_valid);

endmodule

// File: tb/tb_parallel_to_serial_stream.sv
// Directed bench for parallel_to_serial_stream: 8/1 LSB-first instance plus 16/4 MSB-first and LSB-first instances.
module tb_parallel_to_serial_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       pv0, sr0, pr0, sv0, sl0, busy0;
    logic [7:0] pd0;
    logic [0:0] sd0;

    logic        pv1, sr1, pr1, sv1, sl1, busy1;
    logic [15:0] pd1;
    logic [3:0]  sd1;

    logic        pv2, sr2, pr2, sv2, sl2, busy2;
    logic [15:0] pd2;
    logic [3:0]  sd2;

    int vectors     = 0;
    int miscompares = 0;

    parallel_to_serial_stream #(.WIDTH(8), .LANE(1), .MSB_FIRST(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_parallel_valid(pv0), .o_parallel_ready(pr0), .i_parallel_data(pd0),
        .o_serial_valid(sv0), .i_serial_ready(sr0), .o_serial_data(sd0),
        .o_serial_last(sl0), .o_busy(busy0)
    );

    parallel_to_serial_stream #(.WIDTH(16), .LANE(4), .MSB_FIRST(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_parallel_valid(pv1), .o_parallel_ready(pr1), .i_parallel_data(pd1),
        .o_serial_valid(sv1), .i_serial_ready(sr1), .o_serial_data(sd1),
        .o_serial_last(sl1), .o_busy(busy1)
    );

    parallel_to_serial_stream #(.WIDTH(16), .LANE(4), .MSB_FIRST(0)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_parallel_valid(pv2), .o_parallel_ready(pr2), .i_parallel_data(pd2),
        .o_serial_valid(sv2), .i_serial_ready(sr2), .o_serial_data(sd2),
        .o_serial_last(sl2), .o_busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int exp1[8]  = '{1,0,1,0,0,1,0,1};
    int exp2[16] = '{1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1};
    int exp3[8]  = '{1,1,0,0,0,0,1,1};
    int exp4m[4] = '{1,2,3,4};
    int exp4l[4] = '{4,3,2,1};
    int exp5a[3] = '{1,0,1};
    int exp5b[8] = '{0,0,1,1,1,1,0,0};
    int exp6[8]  = '{1,0,0,0,0,0,0,1};

    initial begin
        rst_n = 1'b0;
        pv0 = 1'b1; pd0 = 8'hFF; sr0 = 1'b1;
        pv1 = 1'b0; pd1 = 16'h0;  sr1 = 1'b1;
        pv2 = 1'b0; pd2 = 16'h0;  sr2 = 1'b1;
        #2;
        chk("rst_ready", pr0, 0);
        chk("rst_valid", sv0, 0);
        chk("rst_data",  sd0, 0);
        chk("rst_last",  sl0, 0);
        chk("rst_busy",  busy0, 0);
        next_cycle();
        next_cycle();
        pv0 = 1'b0;
        rst_n = 1'b1;
        next_cycle();

        // 0xA5 offered for one cycle, sink always ready
        for (int t = 0; t <= 8; t++) begin
            pv0 = (t == 0); pd0 = 8'hA5; sr0 = 1'b1;
            @(negedge clk);
            if (t < 8) begin
                chk($sformatf("a5_data_t%0d", t), sd0, exp1[t]);
                chk($sformatf("a5_last_t%0d", t), sl0, (t == 7));
                chk($sformatf("a5_busy_t%0d", t), busy0, (t != 0));
            end else begin
                chk("a5_valid_end", sv0, 0);
                chk("a5_busy_end",  busy0, 0);
            end
            next_cycle();
        end

        // back-to-back 0x0F then 0xF0 via holding buffer
        for (int t = 0; t <= 16; t++) begin
            pv0 = (t <= 1); pd0 = (t == 0) ? 8'h0F : 8'hF0; sr0 = 1'b1;
            @(negedge clk);
            if (t < 16) begin
                chk($sformatf("b2b_data_t%0d", t), sd0, exp2[t]);
                chk($sformatf("b2b_valid_t%0d", t), sv0, 1);
                chk($sformatf("b2b_last_t%0d", t), sl0, (t == 7 || t == 15));
                chk($sformatf("b2b_ready_t%0d", t), pr0, !(t >= 2 && t <= 7));
            end else begin
                chk("b2b_busy_end",  busy0, 0);
                chk("b2b_valid_end", sv0, 0);
            end
            next_cycle();
        end

        // 0xC3 with alternating backpressure starting stalled
        for (int t = 0; t <= 16; t++) begin
            pv0 = (t == 0); pd0 = 8'hC3; sr0 = t[0];
            @(negedge clk);
            if (t < 16) begin
                chk($sformatf("bp_data_t%0d", t), sd0, exp3[t/2]);
                chk($sformatf("bp_valid_t%0d", t), sv0, 1);
                chk($sformatf("bp_last_t%0d", t), sl0, (t / 2 == 7));
            end else begin
                chk("bp_valid_end", sv0, 0);
            end
            next_cycle();
        end
        sr0 = 1'b1;

        // 16-bit words in 4-bit lanes, both chunk orders
        for (int t = 0; t <= 4; t++) begin
            pv1 = (t == 0); pd1 = 16'h1234; sr1 = 1'b1;
            pv2 = (t == 0); pd2 = 16'h1234; sr2 = 1'b1;
            @(negedge clk);
            if (t < 4) begin
                chk($sformatf("msb_data_t%0d", t), sd1, exp4m[t]);
                chk($sformatf("msb_last_t%0d", t), sl1, (t == 3));
                chk($sformatf("lsb_data_t%0d", t), sd2, exp4l[t]);
                chk($sformatf("lsb_last_t%0d", t), sl2, (t == 3));
            end else begin
                chk("msb_valid_end", sv1, 0);
                chk("lsb_valid_end", sv2, 0);
            end
            next_cycle();
        end

        // reset in the middle of 0x55 with 0xFF waiting in hold
        for (int t = 0; t <= 3; t++) begin
            pv0 = (t <= 1); pd0 = (t == 0) ? 8'h55 : 8'hFF; sr0 = 1'b1;
            @(negedge clk);
            if (t < 3) chk($sformatf("rst55_data_t%0d", t), sd0, exp5a[t]);
            else begin
                chk("rst55_busy_pre", busy0, 1);
                chk("rst55_ready_pre", pr0, 0);
                #2;
                rst_n = 1'b0;
                #1;
                chk("rst55_valid_async", sv0, 0);
                chk("rst55_busy_async",  busy0, 0);
                chk("rst55_ready_async", pr0, 0);
            end
            if (t < 3) next_cycle();
        end
        pv0 = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        for (int t = 0; t <= 8; t++) begin
            pv0 = (t == 0); pd0 = 8'h3C; sr0 = 1'b1;
            @(negedge clk);
            if (t < 8) begin
                chk($sformatf("post_rst_data_t%0d", t), sd0, exp5b[t]);
                chk($sformatf("post_rst_last_t%0d", t), sl0, (t == 7));
            end else begin
                chk("post_rst_valid_end", sv0, 0);
                chk("post_rst_busy_end",  busy0, 0);
            end
            next_cycle();
        end

        // 0x81 accepted while the sink is stalled, released at t5
        for (int t = 0; t <= 13; t++) begin
            pv0 = (t == 0); pd0 = 8'h81; sr0 = (t >= 5);
            @(negedge clk);
            if (t < 5) begin
                chk($sformatf("stall_data_t%0d", t), sd0, 1);
                chk($sformatf("stall_valid_t%0d", t), sv0, 1);
                chk($sformatf("stall_busy_t%0d", t), busy0, (t != 0));
                chk($sformatf("stall_last_t%0d", t), sl0, 0);
            end else if (t < 13) begin
                chk($sformatf("stall_data_t%0d", t), sd0, exp6[t-5]);
                chk($sformatf("stall_last_t%0d", t), sl0, (t == 12));
            end else begin
                chk("stall_valid_end", sv0, 0);
                chk("stall_busy_end",  busy0, 0);
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
